way_data_writer: RTL and testbench
==================================

Name: way_data_writer

Overview:
Write-side counterpart of the way data read path. Accepts cache write requests (CPU write hit or line fill) carrying a one-hot target-way select, data and byte enables. Requests are buffered in a small FIFO and drained one at a time to the selected way: a one-cycle write-enable pulse, then a wait for that way's acknowledge. Sits between the cache controller's hit/fill logic and the way array.

Parameters:
NUM_WAYS, 512, number of ways; width of one-hot select, write-enable and ack vectors
DATA_WIDTH, 32, data word width; multiple of 8
WBUF_DEPTH, 4, write buffer entries; power of two, >= 2
ACK_TIMEOUT, 16, max cycles in WAIT_ACK before entry is dropped; >= 2

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  write request valid
req_ready  out  1  buffer can accept a request
req_way  in  NUM_WAYS  one-hot target way
req_data  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte enables
req_err  out  1  one-cycle pulse: previous accepted request had an illegal select
way_we  out  NUM_WAYS  one-hot write-enable pulse to the target way
way_wdata  out  DATA_WIDTH  write data broadcast to all ways
way_be  out  DATA_WIDTH/8  byte enables broadcast to all ways
way_ack  in  NUM_WAYS  per-way write-complete acknowledge
wr_timeout  out  1  one-cycle pulse: entry dropped on ack timeout
wbuf_count  out  $clog2(WBUF_DEPTH)+1  occupied entries
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async assert, sync-released use on next edge): FIFO empty, FSM IDLE, timeout counter 0.
- Reset output values: req_ready=1, req_err=0, way_we=0, way_wdata=0, way_be=0, wr_timeout=0, wbuf_count=0, busy=0.
- Handshake:
  - Transfer occurs when req_valid && req_ready at a clock edge.
  - req_ready = !full, from registered count.
  - When full, no enqueue even if a pop occurs in the same cycle.
- Select check at transfer:
  - Legal: exactly one bit of req_way set. Entry is enqueued.
  - Illegal: zero or more than one bit set. Request is consumed but not enqueued; req_err=1 in the following cycle only.
- FIFO: circular read/write pointers; wbuf_count tracks occupancy. Same-cycle push and pop leave the count unchanged.
- FSM:
  - IDLE: if FIFO non-empty, go to ISSUE. An entry pushed at edge N is visible in IDLE during cycle N+1, so the earliest way_we is cycle N+2.
  - ISSUE (one cycle): way_we = head select; way_wdata/way_be = head data/be. Go to WAIT_ACK; clear timeout counter.
  - WAIT_ACK:
    - way_we=0. way_wdata/way_be hold head values.
    - Only the ack bit of the head's selected way is honoured; other ack bits are ignored.
    - On ack: pop the head, then go to ISSUE if FIFO count > 1, else IDLE.
    - On no ack: increment the counter. When it reaches ACK_TIMEOUT-1 without ack: pop the head, wr_timeout=1 for one cycle, then ISSUE or IDLE by the same rule.
- way_we is never asserted outside ISSUE. It is never multi-hot and is registered (no combinational path from req_*).
- Entries drain strictly in order; no coalescing.
- busy = (count != 0) || (state != IDLE).
- Reset mid-operation: all buffered entries discarded, no further way_we, outputs return to reset values immediately.

Test Plan:
- NUM_WAYS=8. Push way=8'h04, data=32'hDEADBEEF, be=4'hF at edge 0; ack way 2 two cycles after ISSUE -> way_we=8'h04 for exactly one cycle at cycle 2; way_wdata=DEADBEEF; busy drops after ack; wbuf_count 1 -> 0.
- Push 5 legal requests back-to-back with way_ack held 0 for 3 cycles per write -> req_ready=0 after 4th accept; 5th stalls until first pop; way_we order and data match push order.
- Push way=8'h00, then way=8'h06 -> both consumed; req_err pulses once after each; wbuf_count stays 0; way_we never asserted.
- ACK_TIMEOUT=16, never ack -> wr_timeout one pulse 16 cycles after ISSUE; entry popped; next entry issues in the following cycle.
- Ack asserted on a non-selected way (target 8'h01, ack 8'h02) -> ignored, FSM stays WAIT_ACK; correct ack 8'h01 -> pop.
- Fill 3 entries, deassert rst_n during WAIT_ACK -> way_we=0, wbuf_count=0, busy=0 immediately; after release, no stale writes issued.

Source files
------------

// File: rtl/way_data_writer.sv
// Buffers one-hot way write requests in a small FIFO and drains them in order:
// one write-enable pulse per entry, then a wait for that way's acknowledge or a timeout.
//
// state     | meaning
// stIdle    | nothing in flight; waits for a buffered entry
// stIssue   | one-cycle write-enable pulse to the head entry's way
// stWaitAck | holds head data/be until the selected way acks or the timer expires
module way_data_writer #(
  parameter int NUM_WAYS    = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int WBUF_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [NUM_WAYS-1:0]             req_way,
  input  logic [DATA_WIDTH-1:0]           req_data,
  input  logic [DATA_WIDTH/8-1:0]         req_be,
  output logic                            req_err,
  output logic [NUM_WAYS-1:0]             way_we,
  output logic [DATA_WIDTH-1:0]           way_wdata,
  output logic [DATA_WIDTH/8-1:0]         way_be,
  input  logic [NUM_WAYS-1:0]             way_ack,
  output logic                            wr_timeout,
  output logic [$clog2(WBUF_DEPTH):0]     wbuf_count,
  output logic                            busy
);

  localparam int BeW  = DATA_WIDTH / 8;
  localparam int PtrW = $clog2(WBUF_DEPTH);
  localparam int CntW = PtrW + 1;
  localparam int TmrW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {stIdle, stIssue, stWaitAck} stateT;

  stateT               state, nextState;
  logic [NUM_WAYS-1:0] wayMem  [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] dataMem [WBUF_DEPTH];
  logic [BeW-1:0]      beMem   [WBUF_DEPTH];
  logic [PtrW-1:0]     rdPtr, wrPtr;
  logic [CntW-1:0]     count;
  logic [TmrW-1:0]     tmr, tmrNext;
  logic                errQ;
  logic                full, xfer, legal, push, pop, ackHit;
  logic [NUM_WAYS-1:0] headWay;

  assign full      = (count == CntW'(WBUF_DEPTH));
  assign req_ready = !full;
  assign xfer      = req_valid && req_ready;
  assign legal     = (|req_way) && ((req_way & (req_way - NUM_WAYS'(1))) == '0);
  assign push      = xfer && legal;
  assign headWay   = wayMem[rdPtr];
  assign ackHit    = |(way_ack & headWay);

  // Entry storage needs no reset: outputs are gated by state and count.
  always_ff @(posedge clk) begin
    if (push) begin
      wayMem[wrPtr]  <= req_way;
      dataMem[wrPtr] <= req_data;
      beMem[wrPtr]   <= req_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= stIdle;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      tmr   <= '0;
      errQ  <= 1'b0;
    end else begin
      state <= nextState;
      tmr   <= tmrNext;
      errQ  <= xfer && !legal;
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    nextState  = state;
    tmrNext    = tmr;
    pop        = 1'b0;
    wr_timeout = 1'b0;
    way_we     = '0;
    case (state)
      stIdle: begin
        if (count != '0) nextState = stIssue;
      end
      stIssue: begin
        way_we    = headWay;
        tmrNext   = '0;
        nextState = stWaitAck;
      end
      stWaitAck: begin
        // An ack arriving on the final cycle still wins over the timeout.
        if (ackHit || (tmr == TmrW'(ACK_TIMEOUT - 1))) begin
          pop        = 1'b1;
          wr_timeout = !ackHit;
          nextState  = (count > CntW'(1)) ? stIssue : stIdle;
        end else begin
          tmrNext = tmr + TmrW'(1);
        end
      end
      default: nextState = stIdle;
    endcase
  end

  assign way_wdata  = (state != stIdle) ? dataMem[rdPtr] : '0;
  assign way_be     = (state != stIdle) ? beMem[rdPtr] : '0;
  assign req_err    = errQ;
  assign wbuf_count = count;
  assign busy       = (count != '0) || (state != stIdle);

endmodule

// File: tb/tb_way_data_writer.sv
// Randomized and directed stimulus for way_data_writer, checked every cycle against a
// transaction-level queue model of the write buffer and its issue/ack/timeout timing.
module tb_way_data_writer;

  localparam int NW = 8, DW = 32, BW = 4, DEPTH = 4, TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_err, wr_timeout, busy;
  logic [NW-1:0] req_way, way_we, way_ack;
  logic [DW-1:0] req_data, way_wdata;
  logic [BW-1:0] req_be, way_be;
  logic [2:0]    wbuf_count;

  always #5 clk = ~clk;

  way_data_writer #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_way(req_way), .req_data(req_data), .req_be(req_be), .req_err(req_err),
    .way_we(way_we), .way_wdata(way_wdata), .way_be(way_be), .way_ack(way_ack),
    .wr_timeout(wr_timeout), .wbuf_count(wbuf_count), .busy(busy)
  );

  typedef struct packed {
    logic [NW-1:0] way;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } entryT;

  entryT q[$];
  int    cyc, issueCycle, issueAt, ackDelay;
  bit    outstanding, errExp;
  int    nCmp = 0, nBad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    q.delete();
    outstanding = 0;
    issueAt     = -1;
    errExp      = 0;
  endtask

  // ackMode: 0 silent, 1 random bits, 2 head ack after ackDelay cycles, 3 noise never on head way
  task automatic step(input logic v, input logic [NW-1:0] w, input logic [DW-1:0] d,
                      input logic [BW-1:0] b, input int ackMode, output bit accepted);
    logic [NW-1:0] ack;
    entryT head;
    bit    ackHit, toExp, isIssue;
    int    sz;
    @(negedge clk);
    head = (q.size() != 0) ? q[0] : '0;
    case (ackMode)
      1:       ack = NW'($urandom);
      2:       ack = (outstanding && (cyc - issueCycle >= ackDelay)) ? head.way : '0;
      3:       ack = NW'($urandom) & ~head.way;
      default: ack = '0;
    endcase
    req_valid = v; req_way = w; req_data = d; req_be = b; way_ack = ack;
    #1;
    sz      = q.size();
    isIssue = (cyc == issueAt);
    ackHit  = outstanding && ((ack & head.way) != '0);
    toExp   = outstanding && !ackHit && (cyc - issueCycle == TO);
    check("req_ready", req_ready, sz < DEPTH);
    check("wbuf_count", wbuf_count, sz);
    check("req_err", req_err, errExp);
    check("way_we", way_we, isIssue ? head.way : '0);
    check("way_wdata", way_wdata, (isIssue || outstanding) ? head.data : '0);
    check("way_be", way_be, (isIssue || outstanding) ? head.be : '0);
    check("wr_timeout", wr_timeout, toExp);
    check("busy", busy, (sz != 0) || outstanding || isIssue);

    errExp = 0;
    if (isIssue) begin
      outstanding = 1;
      issueCycle  = cyc;
      issueAt     = -1;
    end else if (ackHit || toExp) begin
      outstanding = 0;
      void'(q.pop_front());
      issueAt = (sz > 1) ? cyc + 1 : -1;
    end else if (!outstanding && issueAt < 0 && sz > 0) begin
      issueAt = cyc + 1;
    end
    accepted = v && (sz < DEPTH);
    if (accepted) begin
      if ($countones(w) == 1) q.push_back('{way: w, data: d, be: b});
      else errExp = 1;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input int mode);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, mode, acc);
  endtask

  task automatic send(input logic [NW-1:0] w, input logic [DW-1:0] d, input logic [BW-1:0] b,
                      input int mode);
    bit acc = 0;
    for (int i = 0; i < 200 && !acc; i++) step(1'b1, w, d, b, mode, acc);
    if (!acc) check("send_accept_bound", 0, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; way_ack = '0;
    #1;
    check("rst_way_we", way_we, 0);
    check("rst_count", wbuf_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_err", req_err, 0);
    check("rst_timeout", wr_timeout, 0);
    check("rst_wdata", way_wdata, 0);
    check("rst_be", way_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int mode;
    logic [NW-1:0] w;
    bit acc;
    rst_n = 1'b0; req_valid = 1'b0; req_way = '0; req_data = '0; req_be = '0; way_ack = '0;
    cyc = 0; issueCycle = 0; ackDelay = 2;
    modelReset();
    doReset();

    // single write, ack two cycles after issue
    ackDelay = 2;
    send(8'h04, 32'hDEADBEEF, 4'hF, 2);
    idle(8, 2);

    // five back-to-back writes, acks withheld three cycles each
    ackDelay = 3;
    for (int i = 0; i < 5; i++) send(NW'(1) << i, 32'h1000_0000 + DW'(i), BW'(i + 1), 2);
    idle(30, 2);

    // illegal selects
    send(8'h00, 32'h1111_1111, 4'h1, 2);
    send(8'h06, 32'h2222_2222, 4'h2, 2);
    idle(4, 2);

    // two entries with no acks: both time out
    send(8'h10, 32'hAAAA_0001, 4'h3, 0);
    send(8'h20, 32'hAAAA_0002, 4'hC, 0);
    idle(40, 0);

    // wrong-way acks ignored, then correct ack
    send(8'h01, 32'hBBBB_0001, 4'h5, 3);
    idle(10, 3);
    ackDelay = 0;
    idle(4, 2);

    // reset in the middle of a wait
    send(8'h02, 32'hCCCC_0001, 4'hF, 0);
    send(8'h04, 32'hCCCC_0002, 4'hF, 0);
    send(8'h08, 32'hCCCC_0003, 4'hF, 0);
    idle(3, 0);
    doReset();
    idle(10, 1);

    // randomized phases
    mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        mode     = $urandom_range(0, 3);
        ackDelay = $urandom_range(1, 5);
      end
      w = ($urandom_range(0, 7) == 0) ? NW'($urandom) : (NW'(1) << $urandom_range(0, NW - 1));
      step($urandom_range(0, 1) == 1, w, $urandom, BW'($urandom), mode, acc);
    end
    idle(60, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
